pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- NB_ADDR, 5, register-file address width.
- NB_CNT, 32, cycle-counter width.
- NB_STALL_CNT, 16, stall-counter width.
REQ-002 Ports, one per line: name, direction, width, meaning.
- i_clock, in, 1, clock; all state updates on rising edge.
- i_reset, in, 1, synchronous, active-high reset.
- i_start, in, 1, start pulse from debug unit.
- i_run_mode, in, 1, 1 = continuous run, 0 = single-step; sampled with i_start.
- i_step, in, 1, single-step pulse.
- i_halt_detected, in, 1, HALT instruction present in writeback.
- i_id_rs_addr, in, NB_ADDR, rs address of the instruction in decode.
- i_id_rt_addr, in, NB_ADDR, rt address of the instruction in decode.
- i_ex_mem_rd_enb, in, 1, load instruction latched in the EX/MEM stage.
- i_ex_rt_addr, in, NB_ADDR, rt destination of that load.
- i_branch_taken, in, 1, branch resolved taken in MEM.
- i_jump_taken, in, 1, jump resolved in MEM.
- o_pc_enb, o_if_id_enb, o_id_ex_enb, o_ex_mem_enb, o_mem_wb_enb, out, 1 each, per-stage enables (drive the stage i_enable inputs).
- o_if_id_flush, o_id_ex_flush, o_ex_mem_flush, out, 1 each, per-stage flushes (drive the stage i_flush inputs).
- o_state, out, 2, FSM state code.
- o_cycle_count, out, NB_CNT, advance cycles executed.
- o_stall_count, out, NB_STALL_CNT, load-use stall cycles inserted.

Function
REQ-003 FSM states and codes: IDLE=00, RUN=01, STEP=10, DONE=11.
REQ-004 IDLE: on i_start, go to RUN if i_run_mode=1, else go to STEP; otherwise hold.
REQ-005 RUN: advance=1 every cycle; i_step is ignored.
REQ-006 STEP: advance=i_step; advance lasts exactly one cycle per step pulse.
REQ-007 From RUN or STEP, i_halt_detected=1 with advance=1 moves the FSM to DONE at the next edge; that cycle still advances.
REQ-008 DONE holds until reset; i_start and i_step are ignored.
REQ-009 In IDLE and DONE, all enables and all flushes are 0.
REQ-010 i_start is ignored outside IDLE.
REQ-011 load_use = i_ex_mem_rd_enb & (i_ex_rt_addr != 0) & ((i_ex_rt_addr == i_id_rs_addr) | (i_ex_rt_addr == i_id_rt_addr)).
REQ-012 redirect = i_branch_taken | i_jump_taken.
REQ-013 All enable/flush outputs are combinational from state and inputs, with zero-cycle latency.
REQ-014 advance=1, no redirect, no load_use: all five enables 1, all flushes 0.
REQ-015 advance=1, load_use, no redirect:
- o_pc_enb=0 and o_if_id_enb=0;
- o_id_ex_flush=1 to insert a bubble;
- o_id_ex_enb, o_ex_mem_enb, o_mem_wb_enb = 1;
- o_stall_count increments.
REQ-016 advance=1, redirect: all enables 1; o_if_id_flush, o_id_ex_flush, o_ex_mem_flush = 1.
REQ-017 Redirect overrides load_use, so no stall is counted.
REQ-018 advance=0: all enables 0 and all flushes 0, regardless of hazards.
REQ-019 o_cycle_count increments on every advance cycle.
REQ-020 o_cycle_count and o_stall_count saturate at all-ones and never wrap.

Reset
REQ-021 On i_reset, the following take effect at the next edge:
- state=IDLE;
- o_cycle_count=0 and o_stall_count=0;
- all enables and flushes are 0 in the reset cycle and in IDLE.
REQ-022 Reset mid-RUN or mid-STEP aborts immediately; reset has priority over every other input.

Verification
REQ-023 Reset, then i_start with i_run_mode=1, then 10 cycles with no hazards -> o_state=01, all enables 1, o_cycle_count=10.
REQ-024 STEP mode with i_step pulsed on 3 non-consecutive cycles -> enables high only on those 3 cycles, o_cycle_count=3.
REQ-025 RUN with load i_ex_rt_addr=5, i_id_rs_addr=5 for one cycle -> o_pc_enb=0, o_if_id_enb=0, o_id_ex_flush=1, o_stall_count=1.
- Repeat with i_ex_rt_addr=0 -> no stall.
REQ-026 RUN with i_branch_taken=1 and a simultaneous load_use -> three flushes 1, o_pc_enb=1, o_stall_count unchanged.
REQ-027 RUN with i_halt_detected=1 -> that cycle advances, then o_state=11 and all enables 0.
- i_start in DONE -> no change.
REQ-028 Force o_cycle_count to all-ones, then advance -> value holds.
- Then i_reset mid-RUN -> o_state=00 and counters 0.

Source files
------------

// File: rtl/pipeline_ctrl_if.sv
// Bundle between the pipeline controller and the rest of the pipeline:
// debug controls and hazard info in, per-stage enables/flushes and status out.
interface pipeline_ctrl_if #(
  parameter int unsigned NB_ADDR      = 5,
  parameter int unsigned NB_CNT       = 32,
  parameter int unsigned NB_STALL_CNT = 16
);
  logic                    i_start;
  logic                    i_run_mode;
  logic                    i_step;
  logic                    i_halt_detected;
  logic [NB_ADDR-1:0]      i_id_rs_addr;
  logic [NB_ADDR-1:0]      i_id_rt_addr;
  logic                    i_ex_mem_rd_enb;
  logic [NB_ADDR-1:0]      i_ex_rt_addr;
  logic                    i_branch_taken;
  logic                    i_jump_taken;
  logic                    o_pc_enb;
  logic                    o_if_id_enb;
  logic                    o_id_ex_enb;
  logic                    o_ex_mem_enb;
  logic                    o_mem_wb_enb;
  logic                    o_if_id_flush;
  logic                    o_id_ex_flush;
  logic                    o_ex_mem_flush;
  logic [1:0]              o_state;
  logic [NB_CNT-1:0]       o_cycle_count;
  logic [NB_STALL_CNT-1:0] o_stall_count;

  modport master (
    input  i_start, i_run_mode, i_step, i_halt_detected, i_id_rs_addr, i_id_rt_addr,
           i_ex_mem_rd_enb, i_ex_rt_addr, i_branch_taken, i_jump_taken,
    output o_pc_enb, o_if_id_enb, o_id_ex_enb, o_ex_mem_enb, o_mem_wb_enb, o_if_id_flush,
           o_id_ex_flush, o_ex_mem_flush, o_state, o_cycle_count, o_stall_count
  );

  modport slave (
    output i_start, i_run_mode, i_step, i_halt_detected, i_id_rs_addr, i_id_rt_addr,
           i_ex_mem_rd_enb, i_ex_rt_addr, i_branch_taken, i_jump_taken,
    input  o_pc_enb, o_if_id_enb, o_id_ex_enb, o_ex_mem_enb, o_mem_wb_enb, o_if_id_flush,
           o_id_ex_flush, o_ex_mem_flush, o_state, o_cycle_count, o_stall_count
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Run/step/halt controller for a 5-stage pipeline: per-stage enables and flushes for
// load-use stalls and branch/jump redirects, plus saturating cycle and stall counters.
module pipeline_ctrl #(
  parameter int unsigned NB_ADDR      = 5,
  parameter int unsigned NB_CNT       = 32,
  parameter int unsigned NB_STALL_CNT = 16
) (
  input  logic            i_clock,
  input  logic            i_reset,
  pipeline_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StStep = 2'b10,
    StDone = 2'b11
  } state_e;

  state_e                  state_q, state_d;
  logic [NB_CNT-1:0]       cycle_q, cycle_d;
  logic [NB_STALL_CNT-1:0] stall_q, stall_d;

  logic               advance;
  logic               load_use;
  logic               redirect;
  logic [NB_ADDR-1:0] ex_rt;

  assign ex_rt    = bus.i_ex_rt_addr;
  assign load_use = bus.i_ex_mem_rd_enb && (ex_rt != '0) &&
                    ((ex_rt == bus.i_id_rs_addr) || (ex_rt == bus.i_id_rt_addr));
  assign redirect = bus.i_branch_taken || bus.i_jump_taken;

  // Reset also gates the controls so the reset cycle itself never advances.
  assign advance = !i_reset &&
                   ((state_q == StRun) || ((state_q == StStep) && bus.i_step));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (bus.i_start) state_d = bus.i_run_mode ? StRun : StStep;
      StRun, StStep: if (advance && bus.i_halt_detected) state_d = StDone;
      StDone: state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cycle_d = cycle_q;
    stall_d = stall_q;
    if (advance && (cycle_q != '1)) cycle_d = cycle_q + NB_CNT'(1);
    if (advance && load_use && !redirect && (stall_q != '1)) begin
      stall_d = stall_q + NB_STALL_CNT'(1);
    end
  end

  always_comb begin
    bus.o_pc_enb       = 1'b0;
    bus.o_if_id_enb    = 1'b0;
    bus.o_id_ex_enb    = 1'b0;
    bus.o_ex_mem_enb   = 1'b0;
    bus.o_mem_wb_enb   = 1'b0;
    bus.o_if_id_flush  = 1'b0;
    bus.o_id_ex_flush  = 1'b0;
    bus.o_ex_mem_flush = 1'b0;
    if (advance) begin
      bus.o_id_ex_enb  = 1'b1;
      bus.o_ex_mem_enb = 1'b1;
      bus.o_mem_wb_enb = 1'b1;
      if (redirect) begin
        // Wrong-path instructions in IF/ID, ID/EX and EX/MEM are squashed.
        bus.o_pc_enb       = 1'b1;
        bus.o_if_id_enb    = 1'b1;
        bus.o_if_id_flush  = 1'b1;
        bus.o_id_ex_flush  = 1'b1;
        bus.o_ex_mem_flush = 1'b1;
      end else if (load_use) begin
        bus.o_id_ex_flush = 1'b1;
      end else begin
        bus.o_pc_enb    = 1'b1;
        bus.o_if_id_enb = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= StIdle;
      cycle_q <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cycle_q <= cycle_d;
      stall_q <= stall_d;
    end
  end

  assign bus.o_state       = state_q;
  assign bus.o_cycle_count = cycle_q;
  assign bus.o_stall_count = stall_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized and directed bench for pipeline_ctrl against a cycle-level reference model.
module tb_pipeline_ctrl;
  localparam int unsigned NbAddr    = 5;
  localparam int unsigned NbCnt     = 8;
  localparam int unsigned NbStall   = 4;
  localparam int unsigned CntMax    = (1 << NbCnt) - 1;
  localparam int unsigned StallMax  = (1 << NbStall) - 1;

  logic i_clock = 1'b0;
  logic i_reset;
  always #5 i_clock = ~i_clock;

  pipeline_ctrl_if #(.NB_ADDR(NbAddr), .NB_CNT(NbCnt), .NB_STALL_CNT(NbStall)) bus ();

  pipeline_ctrl #(.NB_ADDR(NbAddr), .NB_CNT(NbCnt), .NB_STALL_CNT(NbStall)) dut (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Stimulus for the next cycle
  logic t_rst, t_start, t_mode, t_step, t_halt, t_ld, t_br, t_jp;
  logic [NbAddr-1:0] t_rs, t_rt, t_ldrt;

  // Reference model: 0 idle, 1 run, 2 step, 3 done
  int unsigned m_state = 0;
  int unsigned m_cyc   = 0;
  int unsigned m_stall = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_in();
    t_rst = 0; t_start = 0; t_mode = 0; t_step = 0; t_halt = 0;
    t_ld = 0; t_br = 0; t_jp = 0; t_rs = '0; t_rt = '0; t_ldrt = '0;
  endtask

  function automatic logic [7:0] ctl_vec();
    return {bus.o_pc_enb, bus.o_if_id_enb, bus.o_id_ex_enb, bus.o_ex_mem_enb,
            bus.o_mem_wb_enb, bus.o_if_id_flush, bus.o_id_ex_flush, bus.o_ex_mem_flush};
  endfunction

  // One clock: drive at negedge, check controls, step the model at posedge, check state.
  task automatic tick();
    bit adv, lu, rd;
    logic [7:0] exp_ctl;
    @(negedge i_clock);
    i_reset                 = t_rst;
    bus.i_start             = t_start;
    bus.i_run_mode          = t_mode;
    bus.i_step              = t_step;
    bus.i_halt_detected     = t_halt;
    bus.i_id_rs_addr        = t_rs;
    bus.i_id_rt_addr        = t_rt;
    bus.i_ex_mem_rd_enb     = t_ld;
    bus.i_ex_rt_addr        = t_ldrt;
    bus.i_branch_taken      = t_br;
    bus.i_jump_taken        = t_jp;
    #1;
    adv = !t_rst && (m_state == 1 || (m_state == 2 && t_step));
    lu  = t_ld && (t_ldrt != 0) && (t_ldrt == t_rs || t_ldrt == t_rt);
    rd  = t_br || t_jp;
    if (!adv)    exp_ctl = 8'b00000_000;
    else if (rd) exp_ctl = 8'b11111_111;
    else if (lu) exp_ctl = 8'b00111_010;
    else         exp_ctl = 8'b11111_000;
    check("ctl", 32'(ctl_vec()), 32'(exp_ctl));
    @(posedge i_clock);
    if (t_rst) begin
      m_state = 0; m_cyc = 0; m_stall = 0;
    end else if (m_state == 0) begin
      if (t_start) m_state = t_mode ? 1 : 2;
    end else if (adv) begin
      if (m_cyc < CntMax) m_cyc++;
      if (lu && !rd && m_stall < StallMax) m_stall++;
      if (t_halt) m_state = 3;
    end
    #1;
    check("state", 32'(bus.o_state), m_state);
    check("cycle_count", 32'(bus.o_cycle_count), m_cyc);
    check("stall_count", 32'(bus.o_stall_count), m_stall);
  endtask

  task automatic do_reset();
    clear_in(); t_rst = 1; tick(); t_rst = 0;
  endtask

  initial begin
    clear_in();
    do_reset();
    check("reset_state", 32'(bus.o_state), 32'd0);
    check("reset_ctl", 32'(ctl_vec()), 32'd0);

    // Continuous run, ten clean cycles
    t_start = 1; t_mode = 1; tick(); clear_in();
    repeat (10) tick();
    check("run_state", 32'(bus.o_state), 32'd1);
    check("run_cycles", 32'(bus.o_cycle_count), 32'd10);
    check("run_enables", 32'(ctl_vec()), 32'b11111_000);

    // Load-use on rs, then same load to r0
    t_ld = 1; t_ldrt = 5; t_rs = 5; tick();
    check("load_use_stall", 32'(bus.o_stall_count), 32'd1);
    t_ldrt = 0; t_rs = 0; tick();
    check("r0_no_stall", 32'(bus.o_stall_count), 32'd1);

    // Branch with simultaneous load-use: redirect wins
    t_ldrt = 7; t_rt = 7; t_br = 1; tick();
    check("redirect_no_stall", 32'(bus.o_stall_count), 32'd1);
    clear_in();

    // Halt, then start ignored in done
    t_halt = 1; tick(); clear_in();
    check("halt_state", 32'(bus.o_state), 32'd3);
    check("halt_cycles", 32'(bus.o_cycle_count), 32'd14);
    t_start = 1; t_mode = 1; t_step = 1; tick(); clear_in();
    check("done_sticky", 32'(bus.o_state), 32'd3);
    check("done_ctl", 32'(ctl_vec()), 32'd0);

    // Single-step with three separated pulses
    do_reset();
    t_start = 1; t_mode = 0; tick(); clear_in();
    for (int i = 0; i < 7; i++) begin
      t_step = (i % 2 == 0) && (i < 6);
      tick();
    end
    clear_in();
    check("step_state", 32'(bus.o_state), 32'd2);
    check("step_cycles", 32'(bus.o_cycle_count), 32'd3);

    // Saturation of both counters, then reset mid-run
    do_reset();
    t_start = 1; t_mode = 1; tick(); clear_in();
    t_ld = 1; t_ldrt = 3; t_rt = 3;
    repeat (20) tick();
    clear_in();
    check("stall_sat", 32'(bus.o_stall_count), StallMax);
    repeat (CntMax) tick();
    check("cycle_sat", 32'(bus.o_cycle_count), CntMax);
    tick();
    check("cycle_hold", 32'(bus.o_cycle_count), CntMax);
    t_rst = 1; tick(); clear_in();
    check("abort_state", 32'(bus.o_state), 32'd0);
    check("abort_cycles", 32'(bus.o_cycle_count), 32'd0);
    check("abort_stalls", 32'(bus.o_stall_count), 32'd0);

    // Randomized segments
    for (int seg = 0; seg < 8; seg++) begin
      do_reset();
      t_start = 1; t_mode = 1'($urandom_range(0, 1)); tick();
      for (int c = 0; c < 150; c++) begin
        t_rst   = ($urandom % 120) == 0;
        t_start = ($urandom % 10) == 0;
        t_mode  = 1'($urandom_range(0, 1));
        t_step  = ($urandom % 3) == 0;
        t_halt  = ($urandom % 60) == 0;
        t_ld    = 1'($urandom_range(0, 1));
        t_ldrt  = NbAddr'($urandom_range(0, 3));
        t_rs    = NbAddr'($urandom_range(0, 3));
        t_rt    = NbAddr'($urandom_range(0, 3));
        t_br    = ($urandom % 6) == 0;
        t_jp    = ($urandom % 8) == 0;
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
